board_draw_sequencer: RTL

- Walks the 4x4 sliding-puzzle board tile by tile and produces the stream of pixels written to the VGA frame buffer.
- For each tile it raster-fills the tile square, then drives the shared digit-glyph drawer for that tile's value.
- It supplies the glyph drawer's origin, select, enable and counter-reset inputs, and merges fill pixels and glyph pixels into one registered plot stream.
- It sits between the game-state logic (upstream, supplies `board`) and the VGA adapter (downstream, consumes `plot_*`).

---
 rtl/board_draw_if.sv | 34 +++
 rtl/board_draw_sequencer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/board_draw_if.sv
// Bundle between board_draw_sequencer, its game-state/glyph-drawer peers and the VGA adapter.
interface board_draw_if;
  // start is a one-cycle request that is taken only while busy=0 (there is no ready
  // and no queuing). plot is a write strobe with no backpressure: the adapter must
  // accept every cycle in which plot=1.
  logic        start;
  logic [63:0] board;
  logic [7:0]  glyph_x;
  logic [6:0]  glyph_y;
  logic [7:0]  glyph_xorg;
  logic [6:0]  glyph_yorg;
  logic [3:0]  glyph_sel;
  logic        glyph_en;
  logic        glyph_resetn;
  logic        plot;
  logic [7:0]  plot_x;
  logic [6:0]  plot_y;
  logic [2:0]  plot_colour;
  logic        busy;
  logic        done;
  logic [2:0]  state;

  modport master (
    output start, board, glyph_x, glyph_y,
    input  glyph_xorg, glyph_yorg, glyph_sel, glyph_en, glyph_resetn,
    input  plot, plot_x, plot_y, plot_colour, busy, done, state
  );

  modport slave (
    input  start, board, glyph_x, glyph_y,
    output glyph_xorg, glyph_yorg, glyph_sel, glyph_en, glyph_resetn,
    output plot, plot_x, plot_y, plot_colour, busy, done, state
  );
endinterface

// File: rtl/board_draw_sequencer.sv
// Redraws the 4x4 puzzle board: per tile a raster fill, then a digit glyph pass.
// Optional macro BOARD_BORDER_EN draws a one-pixel border on every tile.
module board_draw_sequencer #(
  parameter int       X_ORG         = 32,
  parameter int       Y_ORG         = 12,
  parameter int       TILE          = 24,
  parameter int       GLYPH_CYCLES  = 81,
  parameter logic [2:0] BLANK_COLOUR  = 3'b000,
  parameter logic [2:0] TILE_COLOUR   = 3'b110,
  parameter logic [2:0] DIGIT_COLOUR  = 3'b000,
  parameter logic [2:0] BORDER_COLOUR = 3'b111
) (
  input logic        clk,
  input logic        reset,
  board_draw_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, FILL, GLYPH, NEXT, DONE} state_t;

  localparam int FW = $clog2(TILE);
  localparam int GW = $clog2(GLYPH_CYCLES + 1);

  state_t          state, state_nx;
  logic [63:0]     snap;
  logic [3:0]      idx;
  logic [FW-1:0]   fx, fy;
  logic [GW-1:0]   gcnt;
  logic [7:0]      xorg;
  logic [6:0]      yorg;
  logic [3:0]      sel;

  logic            emit;
  logic [7:0]      px;
  logic [6:0]      py;
  logic [2:0]      pc;
  logic            fill_last;
  logic            edge_px;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    emit      = 1'b0;
    px        = xorg + 8'(fx);
    py        = yorg + 7'(fy);
    fill_last = (fx == FW'(TILE - 1)) && (fy == FW'(TILE - 1));
`ifdef BOARD_BORDER_EN
    edge_px   = (fx == '0) || (fy == '0) || (fx == FW'(TILE - 1)) || (fy == FW'(TILE - 1));
`else
    edge_px   = 1'b0;
`endif
    pc        = edge_px ? BORDER_COLOUR : ((sel != 4'd0) ? TILE_COLOUR : BLANK_COLOUR);
    case (state)
      IDLE:  if (bus.start) state_nx = LOAD;
      LOAD:  state_nx = FILL;
      FILL: begin
        emit = 1'b1;
        if (fill_last) state_nx = (sel != 4'd0) ? GLYPH : NEXT;
      end
      GLYPH: begin
        emit = 1'b1;
        px   = bus.glyph_x;
        py   = bus.glyph_y;
        pc   = DIGIT_COLOUR;
        if (gcnt == GW'(GLYPH_CYCLES - 1)) state_nx = NEXT;
      end
      NEXT:  state_nx = (idx == 4'd15) ? DONE : LOAD;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The plot stream is one stage behind pixel selection, so a tile's last pixel lands during NEXT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap            <= '0;
      idx             <= '0;
      fx              <= '0;
      fy              <= '0;
      gcnt            <= '0;
      xorg            <= '0;
      yorg            <= '0;
      sel             <= '0;
      bus.plot        <= 1'b0;
      bus.plot_x      <= '0;
      bus.plot_y      <= '0;
      bus.plot_colour <= '0;
    end else begin
      bus.plot <= emit;
      if (emit) begin
        bus.plot_x      <= px;
        bus.plot_y      <= py;
        bus.plot_colour <= pc;
      end
      case (state)
        IDLE: if (bus.start) begin
          snap <= bus.board;
          idx  <= '0;
        end
        LOAD: begin
          xorg <= 8'(X_ORG + int'(idx[1:0]) * TILE);
          yorg <= 7'(Y_ORG + int'(idx[3:2]) * TILE);
          sel  <= snap[{idx, 2'b00} +: 4];
          fx   <= '0;
          fy   <= '0;
          gcnt <= '0;
        end
        FILL: begin
          if (fx == FW'(TILE - 1)) begin
            fx <= '0;
            fy <= fy + 1'b1;
          end else begin
            fx <= fx + 1'b1;
          end
        end
        GLYPH: gcnt <= gcnt + 1'b1;
        NEXT:  if (idx != 4'd15) idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.busy         = (state != IDLE);
  assign bus.done         = (state == DONE);
  assign bus.glyph_en     = (state == GLYPH);
  assign bus.glyph_resetn = (state != LOAD);
  assign bus.glyph_xorg   = xorg;
  assign bus.glyph_yorg   = yorg;
  assign bus.glyph_sel    = sel;
  assign bus.state        = state;

endmodule
